// File: rtl/clk_div_multi.sv
// clk_div_multi: NUM_CH programmable clock dividers with per-period tick,
// glitch-free ratio updates at period boundaries and a common phase sync.
module clk_div_multi #(
   parameter int NUM_CH      = 4,
   parameter int DIV_W       = 8,
   parameter int DEFAULT_DIV = 2,
   localparam int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              div_wr_en,
   input  logic [CH_W-1:0]   div_wr_ch,
   input  logic [DIV_W-1:0]  div_wr_val,
   input  logic              sync,
   output logic [NUM_CH-1:0] clk_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] div_busy
);

   localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
   localparam logic [DIV_W-1:0] TWO  = DIV_W'(2);
   localparam logic [DIV_W-1:0] DEFN = DIV_W'(DEFAULT_DIV);

   typedef enum logic {
      S_RUN  = 1'b0,
      S_STOP = 1'b1
   } st_t;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      st_t              st_q;
      st_t              st_d;
      logic [DIV_W-1:0] n_q;
      logic [DIV_W-1:0] n_d;
      logic [DIV_W-1:0] p_q;
      logic [DIV_W-1:0] p_d;
      logic [DIV_W-1:0] cnt_q;
      logic [DIV_W-1:0] cnt_d;
      logic [DIV_W-1:0] half;
      logic [DIV_W-1:0] p_eff;
      logic             pend_q;
      logic             pend_d;
      logic             pend_eff;
      logic             wr_hit;
      logic             wrap;
      logic             do_sync;
      logic             do_stop;
      logic             do_wrap;
      logic             apply;
      logic             clk_q;
      logic             clk_d;
      logic             tick_q;
      logic             tick_d;

      // A write in the current cycle already counts as pending at this edge.
      assign wr_hit   = div_wr_en && (div_wr_ch == CH_W'(i));
      assign pend_eff = pend_q | wr_hit;
      assign p_eff    = wr_hit ? div_wr_val : p_q;

      assign wrap = (cnt_q == n_q - ONE);
      assign half = n_q - (n_q >> 1);

      assign do_sync = sync;
      assign do_stop = !sync && (st_q == S_STOP);
      assign do_wrap = !sync && (st_q == S_RUN) && wrap;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            st_q   <= S_RUN;
            n_q    <= DEFN;
            p_q    <= '0;
            pend_q <= 1'b0;
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
         end else begin
            st_q   <= st_d;
            n_q    <= n_d;
            p_q    <= p_d;
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
         end
      end

      always_comb begin
         st_d   = st_q;
         n_d    = n_q;
         p_d    = p_eff;
         pend_d = pend_eff;
         cnt_d  = cnt_q;
         apply  = 1'b0;
         unique case (1'b1)
            do_sync: begin
               apply = pend_eff;
               cnt_d = '0;
            end
            do_stop: begin
               apply = pend_eff;
               cnt_d = '0;
            end
            do_wrap: begin
               apply = pend_eff;
               cnt_d = '0;
            end
            default: cnt_d = cnt_q + ONE;
         endcase
         if (apply) begin
            n_d    = p_eff;
            pend_d = 1'b0;
            st_d   = (p_eff < TWO) ? S_STOP : S_RUN;
         end
      end

      // High for ceil(N/2) counts, tick on count 0; silent while stopped.
      always_comb begin
         clk_d  = (st_q == S_RUN) && (cnt_q < half);
         tick_d = (st_q == S_RUN) && (cnt_q == '0);
      end

      assign clk_out[i]  = clk_q;
      assign tick[i]     = tick_q;
      assign div_busy[i] = pend_q;
   end

endmodule
